rgb_rx_capture: RTL and testbench

RGB_RX_CAPTURE -- requirements
Module: rgb_rx_capture

---
 rtl/rgb_rx_capture.sv | 213 +++++++++++++++++++++
 tb/tb_rgb_rx_capture.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_rx_capture.sv
// rgb_rx_capture: DE-mode RGB bus capture with frame/line timing recovery.
// Optional measurement block (line length, frame lines, overflow) built with RGB_RX_MEAS_EN.
module rgb_rx_capture #(
    parameter int H_MAX     = 1024,
    parameter int VBLANK_TH = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_de,
    input  logic [23:0] i_rgb,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_data_vld,
    output logic        o_sof,
    output logic        o_eol,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic [10:0] o_line_len,
    output logic [10:0] o_frame_lines,
    output logic        o_meas_vld,
    output logic        o_err_ovf
);

    localparam int            CW   = $clog2(VBLANK_TH + 1);
    localparam logic [CW-1:0] TH   = CW'(VBLANK_TH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [10:0]   XMAX = 11'(H_MAX - 1);
    localparam logic [10:0]   CMAX = 11'h7FF;

    typedef enum logic [1:0] {
        SYNC,
        VBLANK,
        ACTIVE,
        HBLANK
    } state_t;

    state_t        state_q, state_d;
    logic          de1_q;
    logic [23:0]   rgb1_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          vld_q, vld_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic [23:0]   pix_q, pix_d;
    logic          emit;

    assign cnt_inc = cnt_q + ONE;

    // Stage 1 input capture plus stage 2 output and FSM state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SYNC;
            de1_q   <= 1'b0;
            rgb1_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            de1_q   <= i_de;
            rgb1_q  <= i_rgb;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
        end
    end

    // Timing FSM: tracks blanking from the stage-1 DE and builds the stage-2 pixel.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        pix_d   = pix_q;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        emit    = 1'b0;

        unique case (state_q)
            SYNC: begin
                if (de1_q) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TH) begin
                        state_d = VBLANK;
                    end
                end
            end
            VBLANK: begin
                cnt_d = '0;
                if (de1_q) begin
                    emit    = 1'b1;
                    sof_d   = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (de1_q) begin
                    emit = 1'b1;
                    if (x_q != XMAX) begin
                        x_d = x_q + 11'd1;
                    end
                end else begin
                    cnt_d   = ONE;
                    state_d = HBLANK;
                end
            end
            HBLANK: begin
                if (de1_q) begin
                    emit    = 1'b1;
                    cnt_d   = '0;
                    x_d     = '0;
                    state_d = ACTIVE;
                    if (y_q != CMAX) begin
                        y_d = y_q + 11'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TH) begin
                        state_d = VBLANK;
                    end
                end
            end
        endcase

        // The raw input DE is the stage-1 successor of the pixel being emitted.
        if (emit) begin
            vld_d = 1'b1;
            pix_d = rgb1_q;
            eol_d = !i_de;
        end
    end

    assign o_r        = pix_q[7:0];
    assign o_g        = pix_q[15:8];
    assign o_b        = pix_q[23:16];
    assign o_data_vld = vld_q;
    assign o_sof      = sof_q;
    assign o_eol      = eol_q;
    assign o_x        = x_q;
    assign o_y        = y_q;

`ifdef RGB_RX_MEAS_EN
    logic [10:0] len_q, len_d;
    logic [10:0] lines_q, lines_d;
    logic        mvld_q, mvld_d;
    logic        ovf_q, ovf_d;
    logic [11:0] len_sum;
    logic [11:0] lines_sum;
    logic        frame_end;
    logic        ovf_hit;

    // Line length on each end of line, line count when vertical blank is detected.
    always_comb begin
        len_sum   = {1'b0, x_d} + 12'd1;
        lines_sum = {1'b0, y_q} + 12'd1;
        frame_end = (state_q == HBLANK) && !de1_q && (cnt_inc == TH);
        ovf_hit   = (state_q == ACTIVE) && de1_q && (x_q == XMAX);
        len_d     = len_q;
        lines_d   = lines_q;
        mvld_d    = frame_end;
        ovf_d     = ovf_q | ovf_hit;
        if (eol_d) begin
            len_d = len_sum[11] ? CMAX : len_sum[10:0];
        end
        if (frame_end) begin
            lines_d = lines_sum[11] ? CMAX : lines_sum[10:0];
        end
    end

    // Measurement registers; overflow flag is sticky until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q   <= '0;
            lines_q <= '0;
            mvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            len_q   <= len_d;
            lines_q <= lines_d;
            mvld_q  <= mvld_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_line_len    = len_q;
    assign o_frame_lines = lines_q;
    assign o_meas_vld    = mvld_q;
    assign o_err_ovf     = ovf_q;
`else
    assign o_line_len    = '0;
    assign o_frame_lines = '0;
    assign o_meas_vld    = 1'b0;
    assign o_err_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_rx_capture.sv
// tb_rgb_rx_capture: directed checks of rgb_rx_capture (H_MAX=8, VBLANK_TH=16).
// Measurement expectations follow RGB_RX_MEAS_EN.
module tb_rgb_rx_capture;

`ifdef RGB_RX_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_de;
    logic [23:0] i_rgb;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_data_vld, o_sof, o_eol;
    logic [10:0] o_x, o_y, o_line_len, o_frame_lines;
    logic        o_meas_vld, o_err_ovf;

    rgb_rx_capture #(
        .H_MAX     (8),
        .VBLANK_TH (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_de          (i_de),
        .i_rgb         (i_rgb),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_data_vld    (o_data_vld),
        .o_sof         (o_sof),
        .o_eol         (o_eol),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_line_len    (o_line_len),
        .o_frame_lines (o_frame_lines),
        .o_meas_vld    (o_meas_vld),
        .o_err_ovf     (o_err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
        logic [23:0] rgb;
    } pix_t;

    pix_t log_q[$];
    int   n_meas    = 0;
    bit   meas_seen = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   base;
    int   mb;

    // Pixel and measurement monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_data_vld === 1'b1)
            log_q.push_back('{x: o_x, y: o_y, sof: o_sof, eol: o_eol,
                              rgb: {o_b, o_g, o_r}});
        if (o_meas_vld === 1'b1)
            n_meas++;
        if (o_meas_vld || o_err_ovf || o_line_len != 0 || o_frame_lines != 0)
            meas_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_de  = 1'b0;
        i_rgb = '0;
        repeat (n) tick();
    endtask

    function automatic logic [23:0] pix(input int l, input int p);
        if (l == 0 && p == 0)
            return 24'h0000FF;
        return {8'(l + 1), 8'(p), 8'h5A};
    endfunction

    task automatic line(input int l, input int p0, input int n);
        for (int p = p0; p < n; p++) begin
            i_de  = 1'b1;
            i_rgb = pix(l, p);
            tick();
        end
        i_de  = 1'b0;
        i_rgb = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_pix(input int k, input int ex, input int ey,
                           input bit esof, input bit eeol,
                           input logic [23:0] ergb);
        pix_t e;
        int   idx;
        idx = base + k;
        if (idx < log_q.size())
            e = log_q[idx];
        else
            e = 'x;
        chk($sformatf("x[%0d]", k), e.x, ex);
        chk($sformatf("y[%0d]", k), e.y, ey);
        chk($sformatf("sof[%0d]", k), e.sof, esof);
        chk($sformatf("eol[%0d]", k), e.eol, eeol);
        chk($sformatf("rgb[%0d]", k), e.rgb, ergb);
    endtask

    task automatic chk_frame3(input string tag);
        chk({tag, "_cnt"}, log_q.size() - base, 12);
        for (int k = 0; k < 12; k++)
            chk_pix(k, k % 4, k / 4, k == 0, (k % 4) == 3, pix(k / 4, k % 4));
    endtask

    task automatic frame3();
        line(0, 0, 4);
        idle(2);
        line(1, 0, 4);
        idle(2);
        line(2, 0, 4);
        idle(20);
    endtask

    initial begin
        i_rst = 1'b1;
        i_de  = 1'b0;
        i_rgb = '0;
        repeat (3) tick();
        chk("rst_vld", o_data_vld, 0);
        chk("rst_sof", o_sof, 0);
        chk("rst_eol", o_eol, 0);
        chk("rst_xy", {o_x, o_y}, 0);
        chk("rst_rgb", {o_r, o_g, o_b}, 0);
        chk("rst_len", o_line_len, 0);
        chk("rst_lines", o_frame_lines, 0);
        chk("rst_mvld", o_meas_vld, 0);
        chk("rst_ovf", o_err_ovf, 0);
        i_rst = 1'b0;

        // Three lines of four pixels, with the 2-cycle latency probe.
        base = log_q.size();
        mb   = n_meas;
        idle(20);
        i_de  = 1'b1;
        i_rgb = pix(0, 0);
        tick();
        chk("lat_c1_vld", o_data_vld, 0);
        i_rgb = pix(0, 1);
        tick();
        chk("lat_c2_vld", o_data_vld, 1);
        chk("lat_c2_r", o_r, 8'hFF);
        chk("lat_c2_g", o_g, 0);
        chk("lat_c2_b", o_b, 0);
        line(0, 2, 4);
        idle(2);
        line(1, 0, 4);
        idle(2);
        line(2, 0, 4);
        idle(20);
        chk_frame3("f1");
        chk("f1_len", o_line_len, MEAS ? 4 : 0);
        chk("f1_lines", o_frame_lines, MEAS ? 3 : 0);
        chk("f1_nmeas", n_meas - mb, MEAS ? 1 : 0);
        chk("f1_ovf", o_err_ovf, 0);

        // Single-pixel frame.
        base = log_q.size();
        line(0, 0, 1);
        idle(20);
        chk("sp_cnt", log_q.size() - base, 1);
        chk_pix(0, 0, 0, 1'b1, 1'b1, pix(0, 0));
        chk("sp_len", o_line_len, MEAS ? 1 : 0);
        chk("sp_lines", o_frame_lines, MEAS ? 1 : 0);

        // Ten-pixel line against H_MAX=8.
        chk("ov_pre", o_err_ovf, 0);
        base = log_q.size();
        line(0, 0, 10);
        idle(20);
        chk("ov_cnt", log_q.size() - base, 10);
        for (int k = 0; k < 10; k++)
            chk_pix(k, (k < 8) ? k : 7, 0, k == 0, k == 9, pix(0, k));
        chk("ov_flag", o_err_ovf, MEAS ? 1 : 0);
        chk("ov_len", o_line_len, MEAS ? 8 : 0);
        chk("ov_lines", o_frame_lines, MEAS ? 1 : 0);
        idle(5);
        chk("ov_sticky", o_err_ovf, MEAS ? 1 : 0);
        chk("meas_activity", meas_seen, MEAS);

        // DE high straight out of reset; a 15-cycle gap must not sync.
        i_rst = 1'b1;
        tick();
        chk("r2_ovf", o_err_ovf, 0);
        chk("r2_len", o_line_len, 0);
        chk("r2_lines", o_frame_lines, 0);
        chk("r2_vld", o_data_vld, 0);
        base  = log_q.size();
        i_rst = 1'b0;
        i_de  = 1'b1;
        i_rgb = pix(0, 0);
        repeat (10) tick();
        idle(15);
        line(0, 0, 3);
        idle(16);
        line(0, 0, 4);
        idle(20);
        chk("ns_cnt", log_q.size() - base, 4);
        for (int k = 0; k < 4; k++)
            chk_pix(k, k, 0, k == 0, k == 3, pix(0, k));
        chk("ns_lines", o_frame_lines, MEAS ? 1 : 0);

        // Reset pulse in the middle of line 1.
        line(0, 0, 4);
        idle(2);
        line(1, 0, 2);
        i_de  = 1'b1;
        i_rgb = pix(1, 2);
        i_rst = 1'b1;
        tick();
        chk("mr_vld", o_data_vld, 0);
        chk("mr_xy", {o_x, o_y}, 0);
        chk("mr_rgb", {o_r, o_g, o_b}, 0);
        chk("mr_len", o_line_len, 0);
        chk("mr_lines", o_frame_lines, 0);
        base  = log_q.size();
        mb    = n_meas;
        i_rst = 1'b0;
        i_rgb = pix(1, 3);
        tick();
        chk("mr_post_vld", o_data_vld, 0);
        idle(2);
        line(2, 0, 4);
        idle(20);
        frame3();
        chk_frame3("f2");
        chk("f2_nmeas", n_meas - mb, MEAS ? 1 : 0);
        chk("f2_lines", o_frame_lines, MEAS ? 3 : 0);
        chk("f2_len", o_line_len, MEAS ? 4 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
